video_timing: RTL and testbench
===============================

VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640, SHALL set the number of visible pixels per line.
REQ-002 Parameter H_FP, default 16, SHALL set the horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, SHALL set the horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, SHALL set the horizontal back porch in pixels; H_TOTAL = sum of the four (800).
REQ-005 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, SHALL set the vertical equivalents in lines; V_TOTAL = sum (525).
REQ-006 Parameter SYNC_POL, default 0, SHALL set the active sync level (0 = active-low) for both hs and vs.
REQ-007 Reset and clock SHALL be: reset resetn, synchronous, active-low; clock clk.
REQ-008 Port clk, input, 1: system clock.
REQ-009 Port resetn, input, 1: synchronous active-low reset.
REQ-010 Port pix_ce, input, 1: pixel clock enable; all timing state advances only on clk edges with pix_ce=1.
REQ-011 Ports x, y, output, 12 each: current raw horizontal/vertical counter values presented to the tile renderer.
REQ-012 Ports r, g, b, input, 8 each: renderer colour for the current x,y, sampled combinationally.
REQ-013 Port test_en, input, 1: test-pattern select (used only per REQ-030).
REQ-014 Ports hdmi_d (output, 24, {r,g,b}), hdmi_de, hdmi_hs, hdmi_vs (output, 1 each): registered transmitter outputs.
REQ-015 Ports frame_start and line_start, output, 1 each: single-clk strobes.

Function
REQ-016 hcnt SHALL count 0..H_TOTAL-1 on each pix_ce and wrap to 0; vcnt SHALL increment on hcnt wrap, counting 0..V_TOTAL-1 and wrapping to 0.
REQ-017 x SHALL equal hcnt and y SHALL equal vcnt, zero-extended to 12 bits and combinational from the counters.
REQ-018 The active region SHALL be defined as hcnt<H_ACTIVE AND vcnt<V_ACTIVE.
REQ-019 The hsync window SHALL be H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
REQ-020 The vsync window SHALL be V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, where vsync transitions coincide with hcnt=0.
REQ-021 On each pix_ce, the output register SHALL capture: hdmi_de = active; hdmi_d = active ? {r,g,b} : 0; hdmi_hs/hdmi_vs = window ? SYNC_POL : !SYNC_POL.
REQ-022 Latency SHALL be exactly one pix_ce tick between a counter value on x,y and its corresponding d/de/hs/vs on the outputs.
REQ-023 With pix_ce=0, counters and all outputs SHALL hold their values.
REQ-024 line_start SHALL be high for exactly one clk on the pix_ce edge at which hcnt goes H_TOTAL-1 -> 0.
REQ-025 frame_start SHALL be high for exactly one clk when, additionally, vcnt goes V_TOTAL-1 -> 0; both strobes are coincident at that edge.

Reset
REQ-026 While resetn=0 on a clk edge, regardless of pix_ce: hcnt=vcnt=0, hdmi_d=0, hdmi_de=0, hdmi_hs=hdmi_vs=!SYNC_POL, frame_start=line_start=0.
REQ-027 After reset deasserts mid-frame, counting SHALL restart from (0,0) on the first pix_ce; no strobe SHALL be issued for that restart.

Configuration
REQ-028 Macro VIDEO_TIMING_TESTPAT_EN SHALL compile in the test-pattern generator.
REQ-029 Without the macro, test_en SHALL be ignored and hdmi_d SHALL follow REQ-021.
REQ-030 With the macro and test_en=1, active-region hdmi_d SHALL be the colour bars: bar = x[8:6]; R = bar[2]?FF:00, G = bar[1]?FF:00, B = bar[0]?FF:00; latency, sync and de SHALL be unchanged.

Structure
REQ-031 Package video_pkg SHALL hold the default timing constants, the 24-bit rgb typedef and the SYNC_POL encoding.
REQ-032 Sub-module video_mod_counter (modulo-N counter with enable and wrap strobe) SHALL be instantiated twice, for hcnt and vcnt.

Verification
REQ-033 Free-running pix_ce=1 for 420000 clks -> frame_start period 420000, line_start period 800, de high for 640 of every 800 pixels on 480 lines.
REQ-034 At hcnt=656 with SYNC_POL=0 -> hdmi_hs=0 on the next edge for exactly 96 pix_ce ticks; vs low exactly on vcnt 490..491.
REQ-035 Drive r,g,b=0x12,0x34,0x56 when x,y=(5,7) -> hdmi_d=0x123456 one pix_ce later; in blanking -> hdmi_d=0.
REQ-036 pix_ce every other clk with resetn pulled low at x=300,y=200 -> next outputs de=0, hs=vs=1, d=0; counting resumes at (0,0) with no strobe.
REQ-037 With VIDEO_TIMING_TESTPAT_EN and test_en=1 at x=64 -> hdmi_d=0x0000FF; at x=448 -> 0xFFFFFF; without the macro -> hdmi_d follows r,g,b.

Source files
------------

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// video_pkg : default 640x480@60 timing constants, pixel type, sync polarity.
// Revision  : 1.0
// ============================================================================
package video_pkg;

    localparam int CNT_W = 12;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    typedef logic [23:0] rgb_t;

    // Drive the asserted level inside the sync window, the idle level outside.
    function automatic logic sync_level(input logic in_window, input bit pol);
        return in_window ? pol : ~pol;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_mod_counter.sv
`default_nettype none
// ============================================================================
// video_mod_counter : modulo-N counter with enable and combinational wrap strobe.
// Revision          : 1.0
// ============================================================================
module video_mod_counter #(
    parameter int N = 800,
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] c_LAST = W'(N - 1);

    logic [W-1:0] r_cnt;

    assign wrap = en && (r_cnt == c_LAST);
    assign cnt  = r_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= wrap ? '0 : r_cnt + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/video_timing.sv
`default_nettype none
// ============================================================================
// video_timing : raster counters plus registered HDMI-style d/de/hs/vs outputs.
// Optional colour-bar generator compiled in by VIDEO_TIMING_TESTPAT_EN.
// Revision     : 1.0
// ============================================================================
module video_timing
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pix_ce,
    output logic [11:0] x,
    output logic [11:0] y,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        test_en,
    output logic [23:0] hdmi_d,
    output logic        hdmi_de,
    output logic        hdmi_hs,
    output logic        hdmi_vs,
    output logic        frame_start,
    output logic        line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] c_H_ACTIVE = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_H_SYNC_S = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_H_SYNC_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_V_ACTIVE = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_V_SYNC_S = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_V_SYNC_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] w_hcnt;
    logic [CNT_W-1:0] w_vcnt;
    logic             w_hwrap;
    logic             w_vwrap;
    logic             w_active;
    logic             w_hs_win;
    logic             w_vs_win;
    rgb_t             w_colour;

    rgb_t r_d;
    logic r_de;
    logic r_hs;
    logic r_vs;
    logic r_frame_start;
    logic r_line_start;

    video_mod_counter #(
        .N (H_TOTAL),
        .W (CNT_W)
    ) u_hcnt (
        .clk    (clk),
        .resetn (resetn),
        .en     (pix_ce),
        .cnt    (w_hcnt),
        .wrap   (w_hwrap)
    );

    // Vertical counter steps only on the horizontal wrap, so vsync edges land on hcnt=0.
    video_mod_counter #(
        .N (V_TOTAL),
        .W (CNT_W)
    ) u_vcnt (
        .clk    (clk),
        .resetn (resetn),
        .en     (w_hwrap),
        .cnt    (w_vcnt),
        .wrap   (w_vwrap)
    );

    assign x = w_hcnt;
    assign y = w_vcnt;

    assign w_active = (w_hcnt < c_H_ACTIVE) && (w_vcnt < c_V_ACTIVE);
    assign w_hs_win = (w_hcnt >= c_H_SYNC_S) && (w_hcnt < c_H_SYNC_E);
    assign w_vs_win = (w_vcnt >= c_V_SYNC_S) && (w_vcnt < c_V_SYNC_E);

`ifdef VIDEO_TIMING_TESTPAT_EN
    logic [2:0] w_bar;
    assign w_bar    = w_hcnt[8:6];
    assign w_colour = test_en ? {{8{w_bar[2]}}, {8{w_bar[1]}}, {8{w_bar[0]}}} : {r, g, b};
`else
    logic w_unused_test_en;
    assign w_unused_test_en = test_en;
    assign w_colour         = {r, g, b};
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_d           <= '0;
            r_de          <= 1'b0;
            r_hs          <= ~SYNC_POL;
            r_vs          <= ~SYNC_POL;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            // Strobes are single-clk pulses even when pix_ce is slower than clk.
            r_line_start  <= w_hwrap;
            r_frame_start <= w_hwrap && w_vwrap;
            if (pix_ce) begin
                r_de <= w_active;
                r_d  <= w_active ? w_colour : '0;
                r_hs <= sync_level(w_hs_win, SYNC_POL);
                r_vs <= sync_level(w_vs_win, SYNC_POL);
            end
        end
    end

    assign hdmi_d      = r_d;
    assign hdmi_de     = r_de;
    assign hdmi_hs     = r_hs;
    assign hdmi_vs     = r_vs;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;

endmodule
`default_nettype wire

// File: tb/tb_video_timing.sv
`default_nettype none
// ============================================================================
// tb_video_timing : randomized bench against a pixel-index reference model.
// Revision        : 1.0
// ============================================================================
module tb_video_timing;

    localparam int HA  = 640;
    localparam int HFP = 16;
    localparam int HS  = 96;
    localparam int HBP = 48;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FR  = HT * VT;
    localparam bit POL = 1'b0;

    logic        clk;
    logic        resetn;
    logic        pix_ce;
    logic [11:0] x;
    logic [11:0] y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        test_en;
    logic [23:0] hdmi_d;
    logic        hdmi_de;
    logic        hdmi_hs;
    logic        hdmi_vs;
    logic        frame_start;
    logic        line_start;

    video_timing #(
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP),
        .SYNC_POL (POL)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pix_ce      (pix_ce),
        .x           (x),
        .y           (y),
        .r           (r),
        .g           (g),
        .b           (b),
        .test_en     (test_en),
        .hdmi_d      (hdmi_d),
        .hdmi_de     (hdmi_de),
        .hdmi_hs     (hdmi_hs),
        .hdmi_vs     (hdmi_vs),
        .frame_start (frame_start),
        .line_start  (line_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference state: position in the frame as a single pixel index.
    int          p = 0;
    logic [23:0] e_d;
    logic        e_de;
    logic        e_hs;
    logic        e_vs;
    logic        e_ls;
    logic        e_fs;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic step(input bit ce, input bit rn, input bit ten);
        logic [7:0]  rr;
        logic [7:0]  gg;
        logic [7:0]  bb;
        logic [23:0] col;
        int          mh;
        int          mv;
        int          bar;
        rr = 8'($urandom);
        gg = 8'($urandom);
        bb = 8'($urandom);
        pix_ce  = ce;
        resetn  = rn;
        r       = rr;
        g       = gg;
        b       = bb;
        test_en = ten;
        mh  = p % HT;
        mv  = p / HT;
        col = {rr, gg, bb};
`ifdef VIDEO_TIMING_TESTPAT_EN
        if (ten) begin
            bar = (mh / 64) % 8;
            col = {(bar & 4) != 0 ? 8'hFF : 8'h00,
                   (bar & 2) != 0 ? 8'hFF : 8'h00,
                   (bar & 1) != 0 ? 8'hFF : 8'h00};
        end
`else
        bar = 0;
`endif
        if (!rn) begin
            p    = 0;
            e_d  = '0;
            e_de = 1'b0;
            e_hs = ~POL;
            e_vs = ~POL;
            e_ls = 1'b0;
            e_fs = 1'b0;
        end else if (ce) begin
            e_de = (mh < HA) && (mv < VA);
            e_d  = e_de ? col : 24'h0;
            e_hs = (mh >= HA + HFP && mh < HA + HFP + HS) ? POL : ~POL;
            e_vs = (mv >= VA + VFP && mv < VA + VFP + VS) ? POL : ~POL;
            e_ls = (mh == HT - 1);
            e_fs = (p == FR - 1);
            p    = (p + 1) % FR;
        end else begin
            e_ls = 1'b0;
            e_fs = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("x",           32'(x),           32'(p % HT));
        check("y",           32'(y),           32'(p / HT));
        check("hdmi_d",      32'(hdmi_d),      32'(e_d));
        check("hdmi_de",     32'(hdmi_de),     32'(e_de));
        check("hdmi_hs",     32'(hdmi_hs),     32'(e_hs));
        check("hdmi_vs",     32'(hdmi_vs),     32'(e_vs));
        check("line_start",  32'(line_start),  32'(e_ls));
        check("frame_start", 32'(frame_start), 32'(e_fs));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ce;
        bit rn;
        bit done;
        int last_fs;
        int last_ls;
        int de_cnt;
        int n_fs;

        pix_ce  = 1'b0;
        resetn  = 1'b0;
        r       = '0;
        g       = '0;
        b       = '0;
        test_en = 1'b0;

        // Reset holds regardless of pix_ce.
        for (int i = 0; i < 4; i++) step(i[0], 1'b0, 1'b0);

        // Random pix_ce, colours, test_en and rare resets.
        for (int i = 0; i < 22000; i++) begin
            ce = ($urandom % 4) != 0;
            rn = ($urandom % 6000) != 0;
            step(ce, rn, 1'($urandom));
        end

        // pix_ce every other clk, reset dropped at x=300 on line 5.
        done = 1'b0;
        for (int i = 0; i < 4 * FR && !(done && i > 4 * HT); i++) begin
            ce = i[0];
            rn = 1'b1;
            if (!done && ce && p == 5 * HT + 300) begin
                rn   = 1'b0;
                done = 1'b1;
            end
            step(ce, rn, 1'b0);
        end
        check("mid_reset_hit", 32'(done), 32'd1);

        // Free-running: strobe periods and visible pixels per frame.
        last_fs = -1;
        last_ls = -1;
        de_cnt  = 0;
        n_fs    = 0;
        for (int i = 0; i < 2 * FR + 2 * HT; i++) begin
            step(1'b1, 1'b1, 1'($urandom));
            de_cnt += int'(hdmi_de);
            if (line_start) begin
                if (last_ls >= 0) check("ls_period", 32'(cyc - last_ls), 32'(HT));
                last_ls = cyc;
            end
            if (frame_start) begin
                if (last_fs >= 0) begin
                    check("fs_period", 32'(cyc - last_fs), 32'(FR));
                    check("de_per_frame", 32'(de_cnt), 32'(HA * VA));
                end
                last_fs = cyc;
                de_cnt  = 0;
                n_fs++;
            end
        end
        check("fs_seen", 32'(n_fs >= 2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
